maze_mem_arbiter: RTL and testbench
===================================

// Module: maze_mem_arbiter
// PURPOSE
//  Shares the single-port maze cell RAM between two requesters. Requester A is the
//  VGA renderer: read-only, hard real time, strict priority. Requester B is the game
//  logic: reads and writes for maze generation, collision checks and player marks.
//  Sits between vga_controller/Game_Logic and the maze block RAM, which has a
//  1-cycle synchronous read. Also reports game-side starvation for debug on the SSD.
// PARAMETERS
//  ADDR_W        11    cell address width (40x30 grid = 1200 cells)
//  DATA_W        4     cell word width (wall/visited/player/goal bits)
//  STARVE_LIMIT  1023  consecutive game wait cycles before the starve flag sets
// PORTS
//  clk          in   1       system clock (25 MHz pixel domain)
//  reset_n      in   1       asynchronous, active-low reset
//  vga_req      in   1       VGA read request, sampled every cycle, no handshake
//  vga_addr     in   ADDR_W  VGA read address
//  vga_rdata    out  DATA_W  VGA read data (valid when vga_rvalid)
//  vga_rvalid   out  1       VGA read data valid
//  game_req     in   1       game request; hold stable until game_gnt
//  game_we      in   1       1 = write, 0 = read
//  game_addr    in   ADDR_W  game address
//  game_wdata   in   DATA_W  game write data
//  game_gnt     out  1       1-cycle pulse: game request accepted this cycle
//  game_rdata   out  DATA_W  game read data (valid when game_rvalid)
//  game_rvalid  out  1       game read data valid; no pulse for writes
//  mem_en       out  1       RAM enable (registered)
//  mem_we       out  1       RAM write enable (registered)
//  mem_addr     out  ADDR_W  RAM address (registered)
//  mem_wdata    out  DATA_W  RAM write data (registered)
//  mem_rdata    in   DATA_W  RAM read data, valid 1 cycle after mem_en & !mem_we
//  starve       out  1       sticky: game waited >= STARVE_LIMIT consecutive cycles
//  wait_max     out  10      saturating max observed game wait length (cycles)
// BEHAVIOUR
//  Reset (async, reset_n=0): every output 0, owner=IDLE, tag pipe cleared,
//   counters cleared. An in-flight read is discarded; no rvalid after reset release.
//  Arbitration (cycle N): vga_req=1 -> VGA wins unconditionally, even when starve=1.
//   Else game_req=1 -> game wins and game_gnt=1 in cycle N (combinational from
//   inputs and state). Else no access.
//  Owner FSM (registered at end of cycle N): IDLE | VGA_RD | GAME_RD | GAME_WR;
//   it selects mem_* driven in cycle N+1. Next state = winner of cycle N, IDLE if none.
//   mem_en=1 in all states except IDLE; mem_we=1 only in GAME_WR.
//   mem_addr/mem_wdata hold their last value when IDLE.
//  Read return: a 1-deep tag register records VGA_RD/GAME_RD. In cycle N+2 the matching
//   rvalid=1 and rdata=mem_rdata (pass-through). Read latency = 2 cycles from request.
//   Back-to-back reads, one per cycle, are sustained. The other rvalid stays 0.
//  Write: game_gnt in N; RAM write at the end of N+1. A read of the same address
//   granted in N+1 or later returns the new data (RAM order preserved).
//  Starvation: wait_cnt increments each cycle with game_req=1 & game_gnt=0.
//   It clears on game_gnt and saturates at 1023. wait_max tracks max(wait_cnt).
//   starve sets when wait_cnt reaches STARVE_LIMIT and stays set until reset.
//  game_req dropped before grant: the request is withdrawn, no access, wait_cnt clears.
//  Simultaneous vga_req & game_req: VGA served, game_gnt=0, wait_cnt+1.
// TESTING
//  1 Reset then idle: all outputs 0; mem_en stays 0 with no requests.
//  2 vga_req=1, addr=0x123 for 1 cycle, RAM[0x123]=0xA: mem_en=1, addr=0x123 in N+1;
//    vga_rvalid=1, vga_rdata=0xA in N+2.
//  3 game write addr=0x010, data=0x5, then game read 0x010: gnt pulses in N and N+1;
//    game_rvalid=1, rdata=0x5 in N+3.
//  4 vga_req held 20 cycles, game_req asserted: game_gnt=0 for 20 cycles, gnt in
//    cycle 21; wait_max=20; starve=0.
//  5 STARVE_LIMIT=8, vga_req held 10 cycles with game_req: starve=1 after 8 waits;
//    starve stays 1 after grant.
//  6 Assert reset_n=0 in the cycle after a GAME_RD grant: no game_rvalid; outputs 0.

Source files
------------

// File: rtl/maze_mem_arbiter.sv
// Maze cell RAM arbiter: VGA renderer has strict priority, the game logic gets the leftover cycles.
// Registered RAM port, 1-deep read tag, 2-cycle read latency, and starvation statistics for debug.
module maze_mem_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned STARVE_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic [DATA_W-1:0] game_rdata,
  output logic              game_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve,
  output logic [9:0]        wait_max
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_VGA_RD,
    OWN_GAME_RD,
    OWN_GAME_WR
  } owner_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VGA,
    TAG_GAME
  } tag_e;

  localparam logic [9:0] WAIT_SAT   = 10'd1023;
  localparam logic [9:0] STARVE_CNT = 10'(STARVE_LIMIT);

  owner_e owner_q, owner_d;
  tag_e   tag_q, tag_d;

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [9:0]        wait_cnt_q, wait_cnt_d;
  logic [9:0]        wait_max_q, wait_max_d;
  logic              starve_q, starve_d;
  logic              game_win;

  // Reset gating keeps the combinational grant at 0 while reset_n is held low.
  assign game_win = reset_n & game_req & ~vga_req;

  always_comb begin
    owner_d     = OWN_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (vga_req) begin
      owner_d    = OWN_VGA_RD;
      mem_addr_d = vga_addr;
    end else if (game_req) begin
      owner_d    = game_we ? OWN_GAME_WR : OWN_GAME_RD;
      mem_addr_d = game_addr;
      if (game_we) begin
        mem_wdata_d = game_wdata;
      end
    end
    mem_en_d = (owner_d != OWN_IDLE);
    mem_we_d = (owner_d == OWN_GAME_WR);
  end

  // The tag follows the owner by one cycle so it lines up with the RAM read data.
  always_comb begin
    tag_d = TAG_NONE;
    case (owner_q)
      OWN_VGA_RD:  tag_d = TAG_VGA;
      OWN_GAME_RD: tag_d = TAG_GAME;
      default:     tag_d = TAG_NONE;
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    if (game_req && !game_win) begin
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + 10'd1;
    end
    wait_max_d = (wait_cnt_d > wait_max_q) ? wait_cnt_d : wait_max_q;
    starve_d   = starve_q | (wait_cnt_d >= STARVE_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= OWN_IDLE;
      tag_q       <= TAG_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_cnt_q  <= '0;
      wait_max_q  <= '0;
      starve_q    <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      tag_q       <= tag_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      wait_max_q  <= wait_max_d;
      starve_q    <= starve_d;
    end
  end

  assign game_gnt    = game_win;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign vga_rvalid  = (tag_q == TAG_VGA);
  assign game_rvalid = (tag_q == TAG_GAME);
  assign vga_rdata   = vga_rvalid  ? mem_rdata : '0;
  assign game_rdata  = game_rvalid ? mem_rdata : '0;
  assign starve      = starve_q;
  assign wait_max    = wait_max_q;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Self-checking bench for maze_mem_arbiter: per-cycle vector table plus starvation and reset sequences.
// A second instance with STARVE_LIMIT=8 shares the stimulus to exercise the starve flag.
module tb_maze_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vga_req;
  logic [10:0] vga_addr;
  logic        game_req;
  logic        game_we;
  logic [10:0] game_addr;
  logic [3:0]  game_wdata;
  logic [3:0]  mem_rdata;

  logic [3:0]  vga_rdata, game_rdata, mem_wdata;
  logic        vga_rvalid, game_gnt, game_rvalid, mem_en, mem_we, starve;
  logic [10:0] mem_addr;
  logic [9:0]  wait_max;

  logic [3:0]  vga_rdata_s, game_rdata_s, mem_wdata_s;
  logic        vga_rvalid_s, game_gnt_s, game_rvalid_s, mem_en_s, mem_we_s, starve_s;
  logic [10:0] mem_addr_s;
  logic [9:0]  wait_max_s;

  logic [3:0]  ram [0:2047];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vreq;
    logic [10:0] vaddr;
    logic        greq;
    logic        gwe;
    logic [10:0] gaddr;
    logic [3:0]  gwdata;
    logic        gnt;
    logic        en;
    logic        we;
    logic [10:0] addr;
    logic [3:0]  wdata;
    logic        vrv;
    logic [3:0]  vrd;
    logic        grv;
    logic [3:0]  grd;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  maze_mem_arbiter u_dut (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
    .game_gnt(game_gnt), .game_rdata(game_rdata), .game_rvalid(game_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve(starve), .wait_max(wait_max)
  );

  maze_mem_arbiter #(.STARVE_LIMIT(8)) u_dut_s (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata_s), .vga_rvalid(vga_rvalid_s),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
    .game_gnt(game_gnt_s), .game_rdata(game_rdata_s), .game_rvalid(game_rvalid_s),
    .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
    .mem_rdata(mem_rdata), .starve(starve_s), .wait_max(wait_max_s)
  );

  // Synchronous-read RAM model driven by the main instance's port.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  function automatic vec_t mkVec(input int vreq, input int vaddr, input int greq, input int gwe,
                                 input int gaddr, input int gwdata, input int gnt, input int en,
                                 input int we, input int addr, input int wdata, input int vrv,
                                 input int vrd, input int grv, input int grd);
    vec_t r;
    r.vreq   = 1'(vreq);
    r.vaddr  = 11'(vaddr);
    r.greq   = 1'(greq);
    r.gwe    = 1'(gwe);
    r.gaddr  = 11'(gaddr);
    r.gwdata = 4'(gwdata);
    r.gnt    = 1'(gnt);
    r.en     = 1'(en);
    r.we     = 1'(we);
    r.addr   = 11'(addr);
    r.wdata  = 4'(wdata);
    r.vrv    = 1'(vrv);
    r.vrd    = 4'(vrd);
    r.grv    = 1'(grv);
    r.grd    = 4'(grd);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    vga_req    = v.vreq;
    vga_addr   = v.vaddr;
    game_req   = v.greq;
    game_we    = v.gwe;
    game_addr  = v.gaddr;
    game_wdata = v.gwdata;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d gnt", i),     32'(game_gnt),    32'(v.gnt));
    checkOutput($sformatf("v%0d mem_en", i),  32'(mem_en),      32'(v.en));
    checkOutput($sformatf("v%0d mem_we", i),  32'(mem_we),      32'(v.we));
    checkOutput($sformatf("v%0d mem_addr", i), 32'(mem_addr),   32'(v.addr));
    checkOutput($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(v.wdata));
    checkOutput($sformatf("v%0d vga_rvalid", i), 32'(vga_rvalid), 32'(v.vrv));
    checkOutput($sformatf("v%0d game_rvalid", i), 32'(game_rvalid), 32'(v.grv));
    if (v.vrv) checkOutput($sformatf("v%0d vga_rdata", i), 32'(vga_rdata), 32'(v.vrd));
    if (v.grv) checkOutput($sformatf("v%0d game_rdata", i), 32'(game_rdata), 32'(v.grd));
    checkOutput($sformatf("v%0d s gnt", i),    32'(game_gnt_s),  32'(v.gnt));
    checkOutput($sformatf("v%0d s mem_en", i), 32'(mem_en_s),    32'(v.en));
    checkOutput($sformatf("v%0d s mem_we", i), 32'(mem_we_s),    32'(v.we));
    checkOutput($sformatf("v%0d s mem_addr", i), 32'(mem_addr_s), 32'(v.addr));
    checkOutput($sformatf("v%0d s mem_wdata", i), 32'(mem_wdata_s), 32'(v.wdata));
    checkOutput($sformatf("v%0d s vga_rvalid", i), 32'(vga_rvalid_s), 32'(v.vrv));
    checkOutput($sformatf("v%0d s game_rvalid", i), 32'(game_rvalid_s), 32'(v.grv));
    if (v.vrv) checkOutput($sformatf("v%0d s vga_rdata", i), 32'(vga_rdata_s), 32'(v.vrd));
    if (v.grv) checkOutput($sformatf("v%0d s game_rdata", i), 32'(game_rdata_s), 32'(v.grd));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " gnt"},         32'(game_gnt),      32'd0);
    checkOutput({tag, " mem_en"},      32'(mem_en),        32'd0);
    checkOutput({tag, " mem_we"},      32'(mem_we),        32'd0);
    checkOutput({tag, " mem_addr"},    32'(mem_addr),      32'd0);
    checkOutput({tag, " mem_wdata"},   32'(mem_wdata),     32'd0);
    checkOutput({tag, " vga_rvalid"},  32'(vga_rvalid),    32'd0);
    checkOutput({tag, " vga_rdata"},   32'(vga_rdata),     32'd0);
    checkOutput({tag, " game_rvalid"}, 32'(game_rvalid),   32'd0);
    checkOutput({tag, " game_rdata"},  32'(game_rdata),    32'd0);
    checkOutput({tag, " starve"},      32'(starve),        32'd0);
    checkOutput({tag, " wait_max"},    32'(wait_max),      32'd0);
    checkOutput({tag, " s starve"},    32'(starve_s),      32'd0);
    checkOutput({tag, " s wait_max"},  32'(wait_max_s),    32'd0);
    checkOutput({tag, " s gnt"},       32'(game_gnt_s),    32'd0);
    checkOutput({tag, " s game_rvalid"}, 32'(game_rvalid_s), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) ram[a] = 4'h0;
    ram[11'h123] = 4'hA;
    ram[11'h200] = 4'h3;

    //                vreq vaddr  greq gwe gaddr  gwd  gnt en we addr   wd vrv vrd grv grd
    vecs[0]  = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 0, 0, 'h000, 0, 0, 0,   0, 0);
    vecs[1]  = mkVec(1, 'h123, 0, 0, 'h000, 0,   0, 0, 0, 'h000, 0, 0, 0,   0, 0);
    vecs[2]  = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 1, 0, 'h123, 0, 0, 0,   0, 0);
    vecs[3]  = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 0, 0, 'h123, 0, 1, 'hA, 0, 0);
    vecs[4]  = mkVec(0, 'h000, 1, 1, 'h010, 5,   1, 0, 0, 'h123, 0, 0, 0,   0, 0);
    vecs[5]  = mkVec(0, 'h000, 1, 0, 'h010, 0,   1, 1, 1, 'h010, 5, 0, 0,   0, 0);
    vecs[6]  = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 1, 0, 'h010, 5, 0, 0,   0, 0);
    vecs[7]  = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 0, 0, 'h010, 5, 0, 0,   1, 5);
    vecs[8]  = mkVec(1, 'h200, 1, 0, 'h123, 0,   0, 0, 0, 'h010, 5, 0, 0,   0, 0);
    vecs[9]  = mkVec(0, 'h000, 1, 0, 'h123, 0,   1, 1, 0, 'h200, 5, 0, 0,   0, 0);
    vecs[10] = mkVec(1, 'h010, 0, 0, 'h000, 0,   0, 1, 0, 'h123, 5, 1, 3,   0, 0);
    vecs[11] = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 1, 0, 'h010, 5, 0, 0,   1, 'hA);
    vecs[12] = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 0, 0, 'h010, 5, 1, 5,   0, 0);
    vecs[13] = mkVec(1, 'h123, 1, 0, 'h300, 0,   0, 0, 0, 'h010, 5, 0, 0,   0, 0);
    vecs[14] = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 1, 0, 'h123, 5, 0, 0,   0, 0);
    vecs[15] = mkVec(0, 'h000, 0, 0, 'h000, 0,   0, 0, 0, 'h123, 5, 1, 'hA, 0, 0);

    reset_n    = 1'b0;
    vga_req    = 1'b0;
    vga_addr   = '0;
    game_req   = 1'b0;
    game_we    = 1'b0;
    game_addr  = '0;
    game_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
    end

    // Starvation: VGA holds the RAM for 20 cycles while the game waits for a read of 0x200.
    @(posedge clk);
    #1;
    vga_req   = 1'b1;
    vga_addr  = 11'h123;
    game_req  = 1'b1;
    game_we   = 1'b0;
    game_addr = 11'h200;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checkOutput($sformatf("starve wait%0d gnt", k), 32'(game_gnt), 32'd0);
      if (k == 8) checkOutput("starve8 s starve before limit", 32'(starve_s), 32'd0);
      if (k == 9) checkOutput("starve8 s starve after limit", 32'(starve_s), 32'd1);
      @(posedge clk);
      #1;
    end
    vga_req = 1'b0;
    @(negedge clk);
    checkOutput("starve grant gnt", 32'(game_gnt), 32'd1);
    checkOutput("starve wait_max", 32'(wait_max), 32'd20);
    checkOutput("starve s wait_max", 32'(wait_max_s), 32'd20);
    checkOutput("starve flag default limit", 32'(starve), 32'd0);
    checkOutput("starve s flag at grant", 32'(starve_s), 32'd1);
    @(posedge clk);
    #1;
    game_req = 1'b0;
    @(negedge clk);
    checkOutput("starve s flag sticky", 32'(starve_s), 32'd1);
    checkOutput("starve wait_max held", 32'(wait_max), 32'd20);
    checkOutput("starve rd mem_addr", 32'(mem_addr), 32'h200);
    @(posedge clk);
    @(negedge clk);
    checkOutput("starve rd game_rvalid", 32'(game_rvalid), 32'd1);
    checkOutput("starve rd game_rdata", 32'(game_rdata), 32'd3);
    checkOutput("starve rd vga_rvalid", 32'(vga_rvalid), 32'd0);

    // Reset lands in the cycle after a game read grant; the read must never return.
    @(posedge clk);
    #1;
    game_req  = 1'b1;
    game_we   = 1'b0;
    game_addr = 11'h123;
    @(negedge clk);
    checkOutput("rst grant gnt", 32'(game_gnt), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    checkResetState("rst mid");
    @(posedge clk);
    #1;
    game_req = 1'b0;
    reset_n  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst after%0d game_rvalid", k), 32'(game_rvalid), 32'd0);
      checkOutput($sformatf("rst after%0d vga_rvalid", k), 32'(vga_rvalid), 32'd0);
      checkOutput($sformatf("rst after%0d mem_en", k), 32'(mem_en), 32'd0);
      @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
